// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one uart_tx serializer
// between N_REQ byte requesters.
//
// Ports:
//   clk_baud     baud-rate clock shared with uart_tx
//   rst          synchronous active-high reset
//   req          per-requester request level
//   req_data     byte for requester i on [8i+7:8i]
//   ack          one-cycle pulse on bit i when requester i's byte is sent
//   busy         high from grant until return to IDLE
//   grant_id     index of the current or last granted requester
//   timeout_err  one-cycle pulse when a frame is aborted by timeout
//   uart_data    byte to uart_tx, stable for the whole frame
//   uart_start   start strobe to uart_tx
//   uart_done    frame-complete indication from uart_tx
module uart_tx_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned IDW          = 2,
    parameter int unsigned START_CYCLES = 2,
    parameter int unsigned TIMEOUT      = 20
) (
    input  logic                 clk_baud,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     ack,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 timeout_err,
    output logic [7:0]           uart_data,
    output logic                 uart_start,
    input  logic                 uart_done
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_GAP
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IDW-1:0]   rr_q, rr_d;
    logic [IDW-1:0]   gid_q, gid_d;
    logic [7:0]       data_q, data_d;
    logic             busy_q, busy_d;
    logic             start_q, start_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             tmo_q, tmo_d;

    logic             win_found;
    logic [IDW-1:0]   win_idx;
    logic [7:0]       win_byte;
    logic             lo_found;
    logic [IDW-1:0]   lo_idx;
    logic [7:0]       lo_byte;
    logic [N_REQ-1:0]   req_sh;
    logic [8*N_REQ-1:0] data_sh;

    logic [IDW-1:0]   rr_next;
    logic             tmo_hit;

    assign rr_next = (gid_q == IDW'(N_REQ - 1)) ? '0 : gid_q + IDW'(1);
    assign tmo_hit = (cnt_q == CW'(TIMEOUT - 1));

    // Winner search: lowest set bit at or above rr_q, else lowest set bit overall (wrap).
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_byte  = '0;
        lo_found  = 1'b0;
        lo_idx    = '0;
        lo_byte   = '0;
        req_sh    = '0;
        data_sh   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            req_sh  = req >> k;
            data_sh = req_data >> (8 * k);
            if (req_sh[0]) begin
                if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = IDW'(k);
                    lo_byte  = data_sh[7:0];
                end
                if (!win_found && (IDW'(k) >= rr_q)) begin
                    win_found = 1'b1;
                    win_idx   = IDW'(k);
                    win_byte  = data_sh[7:0];
                end
            end
        end
        if (!win_found) begin
            win_found = lo_found;
            win_idx   = lo_idx;
            win_byte  = lo_byte;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        gid_d   = gid_q;
        data_d  = data_q;
        busy_d  = busy_q;
        start_d = 1'b0;
        ack_d   = '0;
        tmo_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // After reset the counter holds off grants for one TIMEOUT
                // period so a frame still running in uart_tx can finish.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (win_found) begin
                    gid_d   = win_idx;
                    data_d  = win_byte;
                    busy_d  = 1'b1;
                    start_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d = cnt_q + CW'(1);
                if (tmo_hit) begin
                    tmo_d   = 1'b1;
                    rr_d    = rr_next;
                    state_d = S_GAP;
                end else if (cnt_q == CW'(START_CYCLES - 1)) begin
                    state_d = S_WAIT;
                end else begin
                    start_d = 1'b1;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                // Completion takes priority over a coincident timeout.
                if (uart_done) begin
                    ack_d   = N_REQ'(1) << gid_q;
                    rr_d    = rr_next;
                    state_d = S_GAP;
                end else if (tmo_hit) begin
                    tmo_d   = 1'b1;
                    rr_d    = rr_next;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_baud) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= CW'(TIMEOUT);
            rr_q    <= '0;
            gid_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            ack_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            gid_q   <= gid_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            ack_q   <= ack_d;
            tmo_q   <= tmo_d;
        end
    end

    assign ack         = ack_q;
    assign busy        = busy_q;
    assign grant_id    = gid_q;
    assign timeout_err = tmo_q;
    assign uart_data   = data_q;
    assign uart_start  = start_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios plus randomized frames
// checked against a frame-level model of grant order and handshake timing.
module tb_uart_tx_arbiter;

    localparam int NSTART = 2;
    localparam int TMO    = 20;

    logic        clk_baud = 1'b0;
    logic        rst      = 1'b1;
    logic [3:0]  req      = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  ack;
    logic        busy;
    logic [1:0]  grant_id;
    logic        timeout_err;
    logic [7:0]  uart_data;
    logic        uart_start;
    logic        uart_done = 1'b0;

    uart_tx_arbiter dut (
        .clk_baud    (clk_baud),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err),
        .uart_data   (uart_data),
        .uart_start  (uart_start),
        .uart_done   (uart_done)
    );

    always #5 clk_baud = ~clk_baud;

    int total = 0;
    int bad   = 0;
    int rr_m  = 0;

    // Per-cycle capture of one frame; index 0 is the first cycle after grant.
    logic       tr_start [64];
    logic       tr_busy  [64];
    logic       tr_to    [64];
    logic [3:0] tr_ack   [64];
    logic [7:0] tr_data  [64];
    int         cap_gid;
    int         cap_wait;
    bit         cap_ok;

    // Model: first set request at or after pointer p, with wrap.
    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int i = 0; i < 4; i++) begin
            if (r[(p + i) % 4]) return (p + i) % 4;
        end
        return -1;
    endfunction

    // Model: done is honoured only in the waiting phase (after start, before timeout).
    function automatic bit frame_acked(input int d);
        return (d >= NSTART) && (d <= TMO - 1);
    endfunction

    // Model: cycle on which ack or timeout_err is visible.
    function automatic int frame_end(input int d);
        return frame_acked(d) ? d + 1 : TMO;
    endfunction

    // Stimulus + capture of one frame; uart_done is high during cycle done_at.
    task automatic do_frame(input logic [3:0] r, input logic [31:0] d, input int done_at,
                            input int chg_k, input logic [3:0] r2, input logic [31:0] d2);
        int len;
        len       = frame_end(done_at) + 2;
        req       = r;
        req_data  = d;
        uart_done = 1'b0;
        cap_ok    = 1'b0;
        cap_wait  = 0;
        while (!cap_ok && cap_wait < 60) begin
            @(negedge clk_baud);
            cap_wait++;
            if (busy === 1'b1) cap_ok = 1'b1;
        end
        if (!cap_ok) return;
        cap_gid = int'(grant_id);
        for (int k = 0; k < len; k++) begin
            if (k > 0) @(negedge clk_baud);
            tr_start[k] = uart_start;
            tr_busy[k]  = busy;
            tr_to[k]    = timeout_err;
            tr_ack[k]   = ack;
            tr_data[k]  = uart_data;
            uart_done   = (k == done_at);
            if (k == chg_k) begin
                req      = r2;
                req_data = d2;
            end
        end
        uart_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        repeat (3) @(negedge clk_baud);
        total++;
        if ({ack, busy, grant_id, timeout_err, uart_data, uart_start} !== 17'd0) begin
            bad++;
            $display("FAIL reset_values: got ack=%b busy=%b gid=%0d to=%b data=%h start=%b, want all zero",
                     ack, busy, grant_id, timeout_err, uart_data, uart_start);
        end
        rst  = 1'b0;
        rr_m = 0;
    endtask

    task automatic test_single();
        int e_gid, e_end;
        logic exp_start, exp_busy, exp_to;
        logic [3:0] exp_ack;
        do_frame(4'b0010, 32'h0000_A500, 12, -1, 4'b0000, 32'h0);
        total++;
        if (!cap_ok || cap_gid !== 1 || tr_data[0] !== 8'hA5) begin
            bad++;
            $display("FAIL single_grant: got ok=%0d gid=%0d data=%h, want ok=1 gid=1 data=a5",
                     cap_ok, cap_gid, tr_data[0]);
        end
        if (cap_ok) begin
            e_gid = rr_pick(4'b0010, rr_m);
            e_end = frame_end(12);
            for (int k = 0; k <= e_end + 1; k++) begin
                exp_start = (k < NSTART);
                exp_busy  = (k <= e_end);
                exp_ack   = (k == e_end) ? (4'b0001 << e_gid) : 4'b0000;
                exp_to    = 1'b0;
                total++;
                if ({tr_start[k], tr_busy[k], tr_to[k], tr_ack[k], tr_data[k]} !==
                    {exp_start, exp_busy, exp_to, exp_ack, 8'hA5}) begin
                    bad++;
                    $display("FAIL single cyc%0d: got start/busy/to/ack/data=%b/%b/%b/%b/%h want %b/%b/%b/%b/a5",
                             k, tr_start[k], tr_busy[k], tr_to[k], tr_ack[k], tr_data[k],
                             exp_start, exp_busy, exp_to, exp_ack);
                end
            end
            rr_m = (e_gid + 1) % 4;
        end
    endtask

    task automatic test_round_robin();
        int order [5];
        int e_gid, e_end;
        logic exp_start, exp_busy;
        logic [3:0] exp_ack;
        logic [7:0] e_byte;
        logic [31:0] d;
        order = '{0, 1, 2, 3, 0};
        d = 32'h4433_2211;
        rst = 1'b1;
        @(negedge clk_baud);
        rst  = 1'b0;
        rr_m = 0;
        for (int f = 0; f < 5; f++) begin
            do_frame(4'b1111, d, 12, -1, 4'b1111, d);
            e_gid  = rr_pick(4'b1111, rr_m);
            e_end  = frame_end(12);
            e_byte = d[8*e_gid +: 8];
            total++;
            if (!cap_ok || cap_gid !== order[f] || cap_gid !== e_gid || (f > 0 && cap_wait !== 1)) begin
                bad++;
                $display("FAIL rr_order f%0d: got ok=%0d gid=%0d wait=%0d, want gid=%0d wait=1",
                         f, cap_ok, cap_gid, cap_wait, order[f]);
            end
            if (cap_ok) begin
                for (int k = 0; k <= e_end + 1; k++) begin
                    exp_start = (k < NSTART);
                    exp_busy  = (k <= e_end);
                    exp_ack   = (k == e_end) ? (4'b0001 << e_gid) : 4'b0000;
                    total++;
                    if ({tr_start[k], tr_busy[k], tr_to[k], tr_ack[k], tr_data[k]} !==
                        {exp_start, exp_busy, 1'b0, exp_ack, e_byte}) begin
                        bad++;
                        $display("FAIL rr f%0d cyc%0d: got start/busy/to/ack/data=%b/%b/%b/%b/%h want %b/%b/0/%b/%h",
                                 f, k, tr_start[k], tr_busy[k], tr_to[k], tr_ack[k], tr_data[k],
                                 exp_start, exp_busy, exp_ack, e_byte);
                    end
                end
            end
            rr_m = (e_gid + 1) % 4;
        end
    endtask

    task automatic test_mid_frame_change();
        bit stable;
        do_frame(4'b0100, 32'h00A7_0000, 12, 4, 4'b0000, 32'h005A_0000);
        stable = cap_ok;
        for (int k = 0; k < 15; k++) if (tr_data[k] !== 8'hA7) stable = 1'b0;
        total++;
        if (!stable || cap_gid !== rr_pick(4'b0100, rr_m) || tr_ack[13] !== 4'b0100) begin
            bad++;
            $display("FAIL mid_frame: got stable=%0d gid=%0d ack13=%b, want stable=1 gid=2 ack13=0100",
                     stable, cap_gid, tr_ack[13]);
        end
        rr_m = 3;
    endtask

    task automatic test_timeout();
        bit no_ack, to_ok;
        do_frame(4'b0011, 32'h0000_BBAA, -1, -1, 4'b0011, 32'h0000_BBAA);
        no_ack = cap_ok;
        to_ok  = cap_ok;
        for (int k = 0; k <= TMO + 1; k++) begin
            if (tr_ack[k] !== 4'b0000) no_ack = 1'b0;
            if (tr_to[k] !== (k == TMO)) to_ok = 1'b0;
        end
        total++;
        if (!no_ack || !to_ok || cap_gid !== rr_pick(4'b0011, rr_m)) begin
            bad++;
            $display("FAIL timeout: got no_ack=%0d to_ok=%0d gid=%0d, want 1 1 gid=0", no_ack, to_ok, cap_gid);
        end
        rr_m = 1;
        do_frame(4'b0011, 32'h0000_BBAA, 12, -1, 4'b0011, 32'h0000_BBAA);
        total++;
        if (!cap_ok || cap_wait !== 1 || cap_gid !== 1 || tr_ack[13] !== 4'b0010 || tr_data[0] !== 8'hBB) begin
            bad++;
            $display("FAIL after_timeout: got wait=%0d gid=%0d ack13=%b data=%h, want wait=1 gid=1 ack13=0010 data=bb",
                     cap_wait, cap_gid, tr_ack[13], tr_data[0]);
        end
        rr_m = 2;
    endtask

    task automatic test_done_at_timeout();
        bit no_to;
        do_frame(4'b0100, 32'h00C5_0000, TMO - 1, -1, 4'b0100, 32'h00C5_0000);
        no_to = cap_ok;
        for (int k = 0; k <= TMO + 1; k++) if (tr_to[k] !== 1'b0) no_to = 1'b0;
        total++;
        if (!no_to || cap_gid !== 2 || tr_ack[TMO] !== 4'b0100) begin
            bad++;
            $display("FAIL done_vs_timeout: got no_to=%0d gid=%0d ack=%b, want no_to=1 gid=2 ack=0100",
                     no_to, cap_gid, tr_ack[TMO]);
        end
        rr_m = 3;
    endtask

    task automatic test_random();
        logic [3:0]  r, r2;
        logic [31:0] d, d2;
        int done_at, chg_k, e_gid, e_end;
        bit e_acked;
        logic exp_start, exp_busy, exp_to;
        logic [3:0] exp_ack;
        logic [7:0] e_byte;
        for (int f = 0; f < 16; f++) begin
            r       = 4'($urandom_range(1, 15));
            d       = $urandom;
            r2      = 4'($urandom_range(0, 15));
            d2      = $urandom;
            chg_k   = int'($urandom_range(1, 8));
            done_at = ($urandom_range(0, 9) < 6) ? 12 : int'($urandom_range(0, 20));
            do_frame(r, d, done_at, chg_k, r2, d2);
            e_gid   = rr_pick(r, rr_m);
            e_end   = frame_end(done_at);
            e_acked = frame_acked(done_at);
            e_byte  = d[8*e_gid +: 8];
            total++;
            if (!cap_ok || cap_wait !== 1 || cap_gid !== e_gid) begin
                bad++;
                $display("FAIL rand f%0d grant: got ok=%0d wait=%0d gid=%0d, want wait=1 gid=%0d",
                         f, cap_ok, cap_wait, cap_gid, e_gid);
            end
            if (cap_ok) begin
                for (int k = 0; k <= e_end + 1; k++) begin
                    exp_start = (k < NSTART);
                    exp_busy  = (k <= e_end);
                    exp_ack   = (k == e_end && e_acked) ? (4'b0001 << e_gid) : 4'b0000;
                    exp_to    = (k == e_end && !e_acked);
                    total++;
                    if ({tr_start[k], tr_busy[k], tr_to[k], tr_ack[k], tr_data[k]} !==
                        {exp_start, exp_busy, exp_to, exp_ack, e_byte}) begin
                        bad++;
                        $display("FAIL rand f%0d cyc%0d done_at=%0d: got start/busy/to/ack/data=%b/%b/%b/%b/%h want %b/%b/%b/%b/%h",
                                 f, k, done_at, tr_start[k], tr_busy[k], tr_to[k], tr_ack[k], tr_data[k],
                                 exp_start, exp_busy, exp_to, exp_ack, e_byte);
                    end
                end
            end
            rr_m = (e_gid + 1) % 4;
        end
    endtask

    task automatic test_reset_mid_frame();
        bit found, quiet;
        req       = 4'b1000;
        req_data  = 32'hC300_0000;
        uart_done = 1'b0;
        found     = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk_baud);
            if (busy === 1'b1) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL rst_mid grant: got no grant within 60 cycles, want grant");
        end
        repeat (5) @(negedge clk_baud);
        rst = 1'b1;
        @(negedge clk_baud);
        total++;
        if ({ack, busy, grant_id, timeout_err, uart_data, uart_start} !== 17'd0) begin
            bad++;
            $display("FAIL rst_mid values: got ack=%b busy=%b gid=%0d to=%b data=%h start=%b, want all zero",
                     ack, busy, grant_id, timeout_err, uart_data, uart_start);
        end
        rst   = 1'b0;
        rr_m  = 0;
        quiet = 1'b1;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk_baud);
            if (busy !== 1'b0) quiet = 1'b0;
        end
        total++;
        if (!quiet) begin
            bad++;
            $display("FAIL rst_holdoff: got grant within %0d cycles of reset release, want none", TMO);
        end
        do_frame(4'b1000, 32'hC300_0000, 12, -1, 4'b1000, 32'hC300_0000);
        total++;
        if (!cap_ok || cap_wait !== 1 || cap_gid !== 3 || tr_data[0] !== 8'hC3 || tr_ack[13] !== 4'b1000) begin
            bad++;
            $display("FAIL rst_regrant: got ok=%0d wait=%0d gid=%0d data=%h ack13=%b, want 1 1 3 c3 1000",
                     cap_ok, cap_wait, cap_gid, tr_data[0], tr_ack[13]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_mid_frame_change();
        test_timeout();
        test_done_at_timeout();
        test_random();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
